// File: rtl/bus_arb_pkg.sv
// Shared types and width helpers for the round-robin bus arbiter.
package bus_arb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_e;

    function automatic int id_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Wide enough to hold MAX_BURST itself, not just MAX_BURST-1.
    function automatic int cnt_width(input int max_burst);
        return (max_burst < 1) ? 1 : $clog2(max_burst + 1);
    endfunction

endpackage

// File: rtl/bus_rr_arbiter_rr_pick.sv
// Rotating-priority picker: first set request at or after ptr_i, wrapping.
module rr_pick
    import bus_arb_pkg::*;
#(
    parameter int N = 4,
    localparam int IW = id_width(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  onehot_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    int j;

    always_comb begin
        onehot_o = '0;
        idx_o    = '0;
        any_o    = 1'b0;
        j        = 0;
        for (int i = 0; i < N; i++) begin
            j = int'(ptr_i) + i;
            if (j >= N) j = j - N;
            if (!any_o && req_i[IW'(j)]) begin
                any_o           = 1'b1;
                idx_o           = IW'(j);
                onehot_o[IW'(j)] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter: grants one requester per burst and forwards its beats
// through a single registered output stage tagged with the source index.
module bus_rr_arbiter
    import bus_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int BUS_WIDTH = 32,
    parameter int MAX_BURST = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*BUS_WIDTH-1:0]   req_data,
    input  logic [NUM_REQ-1:0]             req_last,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic                           out_valid,
    output logic [BUS_WIDTH-1:0]           out_data,
    output logic                           out_last,
    output logic [id_width(NUM_REQ)-1:0]   out_id,
    input  logic                           out_ready,
    output logic [NUM_REQ-1:0]             grant,
    output logic                           dbg_state,
    output logic [id_width(NUM_REQ)-1:0]   dbg_rr_ptr
);

    localparam int ID_W  = id_width(NUM_REQ);
    localparam int CNT_W = cnt_width(MAX_BURST);

    // Handshake: a beat moves on a source port when req_valid[i] && req_ready[i]
    // at a rising edge, and on the slave port when out_valid && out_ready.
    arb_state_e           state_q;
    logic [ID_W-1:0]      grant_idx_q;
    logic [NUM_REQ-1:0]   grant_q;
    logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]     beat_cnt_q, beat_cnt_d;
    logic                 out_valid_q;
    logic [BUS_WIDTH-1:0] out_data_q;
    logic                 out_last_q;
    logic [ID_W-1:0]      out_id_q;

    logic [BUS_WIDTH-1:0] req_data_a [NUM_REQ];
    logic [NUM_REQ-1:0]   pick_onehot;
    logic [ID_W-1:0]      pick_idx;
    logic                 pick_any;
    logic                 slot_free;
    logic                 accept;
    logic                 burst_end;

    for (genvar r = 0; r < NUM_REQ; r++) begin : g_unpack
        assign req_data_a[r] = req_data[r*BUS_WIDTH +: BUS_WIDTH];
    end

    rr_pick #(.N(NUM_REQ)) u_pick (
        .req_i   (req_valid),
        .ptr_i   (rr_ptr_q),
        .onehot_o(pick_onehot),
        .idx_o   (pick_idx),
        .any_o   (pick_any)
    );

    // The output slot can take a new beat when empty or draining this cycle.
    assign slot_free  = !out_valid_q || out_ready;
    assign accept     = (state_q == ST_BUSY) && slot_free && req_valid[grant_idx_q];
    assign beat_cnt_d = beat_cnt_q + CNT_W'(1);
    assign burst_end  = accept &&
                        (req_last[grant_idx_q] || (beat_cnt_d == CNT_W'(MAX_BURST)));
    assign rr_ptr_d   = (grant_idx_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx_q + ID_W'(1);

    assign req_ready  = (state_q == ST_BUSY && slot_free) ? grant_q : '0;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_last   = out_last_q;
    assign out_id     = out_id_q;
    assign grant      = grant_q;
    assign dbg_state  = state_q;
    assign dbg_rr_ptr = rr_ptr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            grant_idx_q <= '0;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            beat_cnt_q  <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_id_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pick_any) begin
                        grant_idx_q <= pick_idx;
                        grant_q     <= pick_onehot;
                        beat_cnt_q  <= '0;
                        state_q     <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (accept) beat_cnt_q <= beat_cnt_d;
                    // A MAX_BURST cut leaves out_last as the source sent it.
                    if (burst_end) begin
                        grant_q  <= '0;
                        rr_ptr_q <= rr_ptr_d;
                        state_q  <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase

            if (accept) begin
                out_valid_q <= 1'b1;
                out_data_q  <= req_data_a[grant_idx_q];
                out_last_q  <= req_last[grant_idx_q];
                out_id_q    <= grant_idx_q;
            end else if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Directed bench for bus_rr_arbiter: per-source beat queues feed the DUT and
// a scoreboard checks every beat taken by the slave.
module tb_bus_rr_arbiter;

    localparam int N  = 4;
    localparam int BW = 32;
    localparam int W  = 2 + 1 + BW;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N*BW-1:0] req_data;
    logic [N-1:0]    req_last;
    logic [N-1:0]    req_ready;
    logic            out_valid;
    logic [BW-1:0]   out_data;
    logic            out_last;
    logic [1:0]      out_id;
    logic            out_ready;
    logic [N-1:0]    grant;
    logic            dbg_state;
    logic [1:0]      dbg_rr_ptr;

    logic [BW:0]     src_q [N][$];
    logic [W-1:0]    exp_q [$];
    logic [N-1:0]    hold;
    int              n_vec = 0;
    int              n_err = 0;

    bus_rr_arbiter #(.NUM_REQ(N), .BUS_WIDTH(BW), .MAX_BURST(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_id    (out_id),
        .out_ready (out_ready),
        .grant     (grant),
        .dbg_state (dbg_state),
        .dbg_rr_ptr(dbg_rr_ptr)
    );

    // Clock / reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Driver tasks
    task automatic present();
        for (int r = 0; r < N; r++) begin
            if (!hold[r] && src_q[r].size() > 0) begin
                req_valid[r]           = 1'b1;
                req_data[r*BW +: BW]   = src_q[r][0][BW-1:0];
                req_last[r]            = src_q[r][0][BW];
            end else begin
                req_valid[r]           = 1'b0;
                req_data[r*BW +: BW]   = '0;
                req_last[r]            = 1'b0;
            end
        end
        #1;
    endtask

    task automatic cycle();
        logic [N-1:0] acc;
        @(negedge clk);
        acc = req_valid & req_ready;
        @(posedge clk);
        #1;
        for (int r = 0; r < N; r++)
            if (acc[r] && src_q[r].size() > 0) void'(src_q[r].pop_front());
        present();
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic push_src(input int r, input logic [BW-1:0] d, input logic l);
        src_q[r].push_back({l, d});
    endtask

    task automatic push_exp(input int id, input logic l, input logic [BW-1:0] d);
        exp_q.push_back({2'(id), l, d});
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int r = 0; r < N; r++) src_q[r].delete();
        present();
        cycles(2);
        rst_n = 1'b1;
    endtask

    // Scoreboard
    initial begin
        logic [W-1:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                check("sb_has_exp", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("sb_beat", 64'({out_id, out_last, out_data}), 64'(e));
                end
            end
        end
    end

    logic [N-1:0] t2_grant [9];

    initial begin
        rst_n     = 1'b0;
        out_ready = 1'b1;
        hold      = '0;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        t2_grant  = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                      4'b0000, 4'b1000, 4'b0000, 4'b0001};
        repeat (2) @(posedge clk);
        #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out_id", out_id, 0);
        check("rst_grant", grant, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_rr_ptr", dbg_rr_ptr, 0);
        check("rst_state", dbg_state, 0);
        rst_n = 1'b1;

        // Single 3-beat burst from requester 1
        push_src(1, 32'hA1, 0); push_src(1, 32'hA2, 0); push_src(1, 32'hA3, 1);
        push_exp(1, 0, 32'hA1); push_exp(1, 0, 32'hA2); push_exp(1, 1, 32'hA3);
        present();
        check("t1_c0_grant", grant, 4'b0000);
        cycle();
        check("t1_c1_grant", grant, 4'b0010);
        check("t1_c1_ready", req_ready, 4'b0010);
        check("t1_c1_ovalid", out_valid, 0);
        cycle();
        check("t1_c2_ovalid", out_valid, 1);
        check("t1_c2_data", out_data, 32'hA1);
        check("t1_c2_id", out_id, 1);
        check("t1_c2_last", out_last, 0);
        cycle();
        check("t1_c3_data", out_data, 32'hA2);
        cycle();
        check("t1_c4_data", out_data, 32'hA3);
        check("t1_c4_last", out_last, 1);
        check("t1_c4_grant", grant, 0);
        check("t1_c4_ptr", dbg_rr_ptr, 2);
        cycles(2);

        // All four requesters, one single-beat burst each, then 0 again
        do_reset();
        for (int r = 0; r < N; r++) begin
            push_src(r, 32'h10 + r, 1);
            push_exp(r, 1, 32'h10 + r);
        end
        push_src(0, 32'h20, 1);
        push_exp(0, 1, 32'h20);
        present();
        for (int c = 0; c < 9; c++) begin
            cycle();
            check($sformatf("t2_c%0d_grant", c + 1), grant, t2_grant[c]);
        end
        cycles(3);

        // 6 beats from requester 2, cut after 4 by MAX_BURST
        for (int b = 0; b < 6; b++) begin
            push_src(2, 32'h31 + b, b == 5);
            push_exp(2, b == 5, 32'h31 + b);
        end
        present();
        for (int c = 1; c <= 8; c++) begin
            cycle();
            check($sformatf("t3_c%0d_grant", c), grant,
                  (c == 5 || c == 8) ? 4'b0000 : 4'b0100);
            if (c == 5) begin
                check("t3_c5_data", out_data, 32'h34);
                check("t3_c5_last", out_last, 0);
            end
        end
        cycles(2);

        // Backpressure for 3 cycles while 0x55 sits in the output stage
        push_src(0, 32'h54, 0); push_src(0, 32'h55, 0); push_src(0, 32'h56, 1);
        push_exp(0, 0, 32'h54); push_exp(0, 0, 32'h55); push_exp(0, 1, 32'h56);
        present();
        cycles(3);
        check("t4_c3_data", out_data, 32'h55);
        out_ready = 1'b0;
        #1;
        check("t4_c3_ready", req_ready, 0);
        check("t4_c3_ovalid", out_valid, 1);
        for (int k = 0; k < 2; k++) begin
            cycle();
            check("t4_bp_data", out_data, 32'h55);
            check("t4_bp_ovalid", out_valid, 1);
            check("t4_bp_ready", req_ready, 0);
            check("t4_bp_id", out_id, 0);
        end
        cycle();
        check("t4_c6_data", out_data, 32'h55);
        out_ready = 1'b1;
        #1;
        check("t4_c6_ready", req_ready, 4'b0001);
        cycle();
        check("t4_c7_data", out_data, 32'h56);
        check("t4_c7_ovalid", out_valid, 1);
        cycles(2);

        // Reset mid-burst while requester 3 owns the bus
        for (int b = 0; b < 4; b++) push_src(3, 32'h61 + b, b == 3);
        push_exp(3, 0, 32'h61);
        present();
        cycle();
        check("t5_c1_grant", grant, 4'b1000);
        cycles(2);
        check("t5_c3_data", out_data, 32'h62);
        rst_n = 1'b0;
        #1;
        check("t5_rst_ovalid", out_valid, 0);
        check("t5_rst_data", out_data, 0);
        check("t5_rst_grant", grant, 0);
        check("t5_rst_ready", req_ready, 0);
        check("t5_rst_ptr", dbg_rr_ptr, 0);
        src_q[3].delete();
        present();
        cycles(2);
        rst_n = 1'b1;
        push_src(3, 32'h71, 1); push_src(0, 32'h70, 1);
        push_exp(0, 1, 32'h70); push_exp(3, 1, 32'h71);
        present();
        cycle();
        check("t5_r_c1_grant", grant, 4'b0001);
        cycle();
        check("t5_r_c2_grant", grant, 4'b0000);
        cycle();
        check("t5_r_c3_grant", grant, 4'b1000);
        cycles(3);

        // Requester 1 stalls mid-burst; requester 0 waits without a timeout
        push_src(1, 32'h81, 0); push_src(1, 32'h82, 0); push_src(1, 32'h83, 1);
        push_exp(1, 0, 32'h81); push_exp(1, 0, 32'h82); push_exp(1, 1, 32'h83);
        push_exp(0, 1, 32'h90);
        present();
        cycle();
        check("t6_c1_grant", grant, 4'b0010);
        push_src(0, 32'h90, 1);
        present();
        cycle();
        check("t6_c2_ready", req_ready, 4'b0010);
        cycle();
        hold[1] = 1'b1;
        present();
        for (int k = 0; k < 5; k++) begin
            cycle();
            check("t6_hold_grant", grant, 4'b0010);
            check("t6_hold_rdy0", req_ready[0], 0);
        end
        hold[1] = 1'b0;
        present();
        check("t6_resume_ready", req_ready, 4'b0010);
        cycle();
        check("t6_end_grant", grant, 0);
        cycle();
        check("t6_next_grant", grant, 4'b0001);
        check("t6_next_ready", req_ready, 4'b0001);
        cycles(4);

        check("exp_q_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
